// File: rtl/router_1xn_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : router_pkg
// Brief    : Shared constants and helpers for the 1-to-N FIFO router.
// Revision : 1.0  initial release
// ============================================================================
package router_pkg;

  // Width of the saturating illegal-select drop counter
  localparam int DROP_CNT_W     = 8;

  // Default geometry of the router
  localparam int DEFAULT_DATA_W  = 4;
  localparam int DEFAULT_NUM_OUT = 3;
  localparam int DEFAULT_DEPTH   = 4;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_1xn_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : router_1xn_fifo_if
// Brief    : Ingress handshake plus flattened per-channel egress handshakes.
//            master = traffic source/sink side, slave = router side.
// Revision : 1.0  initial release
// ============================================================================
interface router_1xn_fifo_if
  import router_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int NUM_OUT = DEFAULT_NUM_OUT,
  parameter int SEL_W   = $clog2(NUM_OUT)
);

  logic [DATA_W-1:0]         data_in;
  logic [SEL_W-1:0]          sel;
  logic                      valid_in;
  logic                      ready_in;
  logic [NUM_OUT*DATA_W-1:0] out_data;
  logic [NUM_OUT-1:0]        out_valid;
  logic [NUM_OUT-1:0]        out_ready;

  modport master (
    output data_in, sel, valid_in, out_ready,
    input  ready_in, out_data, out_valid
  );

  modport slave (
    input  data_in, sel, valid_in, out_ready,
    output ready_in, out_data, out_valid
  );

endinterface
`default_nettype wire

// File: rtl/router_1xn_fifo_fifo.sv
`default_nettype none
// ============================================================================
// Module   : router_fifo
// Brief    : Single-clock circular FIFO with occupancy counter. Head is read
//            straight from storage, so a write is visible one cycle later.
// Revision : 1.0  initial release
// ============================================================================
module router_fifo
  import router_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  // Status flags come from registered occupancy; requests are masked so a
  // full FIFO never overwrites and an empty FIFO never underflows.
  assign full   = (r_count == CNT_W'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign dout   = r_mem[r_rd_ptr];

  // Storage write; contents are left unreset since pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/router_1xn_fifo.sv
`default_nettype none
// ============================================================================
// Module   : router_1xn_fifo
// Brief    : Routes one input stream into NUM_OUT independent FIFOs by sel.
//            Illegal selects are always accepted and counted as drops.
// Revision : 1.0  initial release
// ============================================================================
module router_1xn_fifo
  import router_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int NUM_OUT = DEFAULT_NUM_OUT,
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int SEL_W   = $clog2(NUM_OUT)
) (
  input  logic                  clk,
  input  logic                  rst,
  router_1xn_fifo_if.slave      bus,
  output logic [DROP_CNT_W-1:0] drop_count
);

  logic                  w_sel_legal;
  logic                  w_sel_full;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_drop;
  logic [NUM_OUT-1:0]    w_push;
  logic [NUM_OUT-1:0]    w_full;
  logic [NUM_OUT-1:0]    w_empty;
  logic [DATA_W-1:0]     w_dout [NUM_OUT];
  logic [DROP_CNT_W-1:0] r_drop_count;

  // Ready mux: illegal selects are always sinkable, legal ones need room
  always_comb begin
    w_sel_legal = (int'(bus.sel) < NUM_OUT);
    w_sel_full  = 1'b0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (bus.sel == SEL_W'(k)) w_sel_full = w_full[k];
    end
    w_ready  = w_sel_legal ? ~w_sel_full : 1'b1;
    w_accept = bus.valid_in & w_ready;
    w_drop   = w_accept & ~w_sel_legal;
  end

  assign bus.ready_in = w_ready;

  generate
    for (genvar k = 0; k < NUM_OUT; k++) begin : g_chan
      // Select decode for this channel
      assign w_push[k] = w_accept & w_sel_legal & (bus.sel == SEL_W'(k));

      router_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push[k]),
        .din   (bus.data_in),
        .full  (w_full[k]),
        .pop   (bus.out_ready[k]),
        .dout  (w_dout[k]),
        .empty (w_empty[k])
      );
    end
  endgenerate

  assign bus.out_valid = ~w_empty;

  // Flatten channel heads onto the egress bus
  always_comb begin
    bus.out_data = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      bus.out_data[k*DATA_W +: DATA_W] = w_dout[k];
    end
  end

  // Saturating count of payloads discarded for an out-of-range select
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_drop_count <= sat_inc(r_drop_count);
    end
  end

  assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_router_1xn_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_1xn_fifo
// Brief    : Directed self-checking bench for router_1xn_fifo (3 ch, depth 4).
// Revision : 1.0  initial release
// ============================================================================
module tb_router_1xn_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] drop_count;
  int         n_tests;
  int         n_fail;

  router_1xn_fifo_if #(.DATA_W(4), .NUM_OUT(3), .SEL_W(2)) bus ();

  router_1xn_fifo #(
    .DATA_W  (4),
    .NUM_OUT (3),
    .DEPTH   (4),
    .SEL_W   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .drop_count (drop_count)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] head(input int ch);
    logic [11:0] d;
    d = bus.out_data;
    return d[ch*4 +: 4];
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus.valid_in  = 1'b0;
    bus.sel       = 2'd0;
    bus.data_in   = 4'h0;
    bus.out_ready = 3'b000;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
    chk("reset_drop", 32'(drop_count), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    tick();

    // Basic routing to each channel, out_ready held low
    bus.valid_in = 1'b1; bus.sel = 2'd0; bus.data_in = 4'hA; #1;
    chk("t1_ready_ch0", 32'(bus.ready_in), 32'h1);
    tick();
    chk("t1_latency_valid", 32'(bus.out_valid), 32'h1);
    chk("t1_latency_head0", 32'(head(0)), 32'hA);
    bus.sel = 2'd1; bus.data_in = 4'hC; #1;
    chk("t1_ready_ch1", 32'(bus.ready_in), 32'h1);
    tick();
    bus.sel = 2'd2; bus.data_in = 4'hF;
    tick();
    bus.valid_in = 1'b0;
    chk("t1_out_valid", 32'(bus.out_valid), 32'h7);
    chk("t1_heads", 32'(bus.out_data), 32'hFCA);

    // Illegal select: always ready, counted, saturating
    bus.valid_in = 1'b1; bus.sel = 2'd3; bus.data_in = 4'h5;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_ready_illegal", 32'(bus.ready_in), 32'h1);
      tick();
      chk("t2_drop_inc", 32'(drop_count), 32'(i + 1));
    end
    chk("t2_out_valid_kept", 32'(bus.out_valid), 32'h7);
    chk("t2_heads_kept", 32'(bus.out_data), 32'hFCA);
    for (int i = 0; i < 297; i++) tick();
    bus.valid_in = 1'b0;
    chk("t2_drop_sat", 32'(drop_count), 32'd255);
    bus.out_ready = 3'b111;
    tick();
    bus.out_ready = 3'b000;
    chk("t2_drained", 32'(bus.out_valid), 32'h0);

    // Fill channel 1, overflow refused, drain in order, then idle pops
    bus.valid_in = 1'b1; bus.sel = 2'd1;
    for (int v = 1; v <= 4; v++) begin
      bus.data_in = 4'(v); #1;
      chk("t3_ready_fill", 32'(bus.ready_in), 32'h1);
      tick();
    end
    bus.data_in = 4'h5; #1;
    chk("t3_ready_full", 32'(bus.ready_in), 32'h0);
    tick();
    chk("t3_still_full", 32'(bus.ready_in), 32'h0);
    bus.valid_in = 1'b0;
    bus.out_ready = 3'b010;
    for (int v = 1; v <= 4; v++) begin
      #1;
      chk("t3_valid1", 32'(bus.out_valid[1]), 32'h1);
      chk("t3_order", 32'(head(1)), 32'(v));
      tick();
    end
    chk("t3_empty", 32'(bus.out_valid), 32'h0);
    tick();
    chk("t3_empty_pop_ignored", 32'(bus.out_valid), 32'h0);
    bus.out_ready = 3'b000;
    bus.valid_in = 1'b1; bus.data_in = 4'hE;
    tick();
    bus.valid_in = 1'b0;
    chk("t3_after_underflow_valid", 32'(bus.out_valid), 32'h2);
    chk("t3_after_underflow_head", 32'(head(1)), 32'hE);
    bus.out_ready = 3'b010;
    tick();
    bus.out_ready = 3'b000;
    chk("t3_after_underflow_empty", 32'(bus.out_valid), 32'h0);

    // Full channel popping in the same cycle still refuses the push
    bus.valid_in = 1'b1; bus.sel = 2'd2;
    for (int v = 6; v <= 9; v++) begin
      bus.data_in = 4'(v);
      tick();
    end
    bus.data_in = 4'hA; bus.out_ready = 3'b100; #1;
    chk("t4_no_push_through", 32'(bus.ready_in), 32'h0);
    tick();
    chk("t4_ready_next", 32'(bus.ready_in), 32'h1);
    chk("t4_head_after_pop", 32'(head(2)), 32'h7);
    tick();
    bus.valid_in = 1'b0;
    chk("t4_drain_8", 32'(head(2)), 32'h8);
    tick();
    chk("t4_drain_9", 32'(head(2)), 32'h9);
    tick();
    chk("t4_drain_A", 32'(head(2)), 32'hA);
    tick();
    chk("t4_empty", 32'(bus.out_valid), 32'h0);
    bus.out_ready = 3'b000;

    // Steady push/pop on channel 0 at occupancy 2
    bus.valid_in = 1'b1; bus.sel = 2'd0;
    bus.data_in = 4'h1; tick();
    bus.data_in = 4'h2; tick();
    bus.out_ready = 3'b001;
    for (int i = 0; i < 10; i++) begin
      bus.data_in = 4'(3 + i); #1;
      chk("t5_ready", 32'(bus.ready_in), 32'h1);
      chk("t5_stream", 32'(head(0)), 32'(i + 1));
      tick();
    end
    bus.valid_in = 1'b0;
    chk("t5_tail_11", 32'(head(0)), 32'd11);
    tick();
    chk("t5_tail_12", 32'(head(0)), 32'd12);
    tick();
    chk("t5_occupancy_was_2", 32'(bus.out_valid), 32'h0);
    bus.out_ready = 3'b000;

    // Asynchronous reset mid-operation flushes everything
    bus.valid_in = 1'b1;
    for (int ch = 0; ch < 3; ch++) begin
      for (int j = 0; j < 3; j++) begin
        bus.sel = 2'(ch); bus.data_in = 4'(ch * 4 + j + 1);
        tick();
      end
    end
    bus.valid_in = 1'b0;
    chk("t6_pre_valid", 32'(bus.out_valid), 32'h7);
    chk("t6_pre_drop", 32'(drop_count), 32'd255);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.out_valid), 32'h0);
    chk("t6_rst_drop", 32'(drop_count), 32'h0);
    #1 rst = 1'b1;
    tick();
    bus.valid_in = 1'b1; bus.sel = 2'd0; bus.data_in = 4'hD;
    tick();
    bus.valid_in = 1'b0;
    chk("t6_post_valid", 32'(bus.out_valid), 32'h1);
    chk("t6_post_head", 32'(head(0)), 32'hD);
    bus.out_ready = 3'b001;
    tick();
    bus.out_ready = 3'b000;
    chk("t6_post_alone", 32'(bus.out_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
